egress_meta_queue: RTL and testbench
====================================

EGRESS_META_QUEUE -- requirements
Module: egress_meta_queue

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of egress ports, one queue per port.
REQ-002 Parameter DEPTH, default 4: entries per port queue (power of two).
REQ-003 Parameter META_W, default 31: stored metadata width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 eg_valid  input  NUM_PORTS  per-port one-cycle push strobe from egress.
REQ-007 eg_meta  input  NUM_PORTS x META_W (packed, port 0 in LSBs)  per-port metadata, sampled when the matching eg_valid bit is high.
REQ-008 rd_port  input  2  port selected by the software bus (bus address minus 1).
REQ-009 ack  input  NUM_PORTS  per-port consume indication from the software bus interface; held high for the duration of a read.
REQ-010 meta_rdata  output  32  head word of the selected queue, fed to the bus interface.
REQ-011 empty  output  NUM_PORTS  per-port queue-empty flags.
REQ-012 count  output  NUM_PORTS x 3  per-port occupancy, 0..DEPTH.
REQ-013 drop_cnt  output  NUM_PORTS x 8  per-port saturating overflow counters.

Function
REQ-014 meta_rdata SHALL be combinational: {1'b1, head[rd_port]} when queue rd_port is non-empty, otherwise 32'h0 (bit 31 = valid).
REQ-015 A push on port p SHALL write eg_meta[p] at the tail and increment count[p] on the same clock edge; the entry is visible at meta_rdata one cycle after the strobe.
REQ-016 A pop on port p SHALL occur only on a rising edge of ack[p] (ack[p]=1 this cycle, 0 last cycle); holding ack high SHALL pop exactly once.
REQ-017 A pop on an empty queue SHALL be ignored: no pointer, count, or drop_cnt change.
REQ-018 A push to a full queue without a same-cycle pop SHALL be discarded and SHALL increment drop_cnt[p], saturating at 8'hFF.
REQ-019 A simultaneous push and pop on the same port SHALL both take effect and leave count unchanged, including when the queue is full.
REQ-020 A simultaneous push and pop on an empty queue SHALL pop nothing and SHALL enqueue the pushed word.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; full/empty SHALL derive from count, not from pointer equality.
REQ-022 Ports SHALL be fully independent; events on different ports in the same cycle SHALL not interact.
REQ-023 Queue contents SHALL be in FIFO order per port.

Reset
REQ-024 While reset is high, all pointers, counts, drop_cnt, and the registered ack history SHALL clear to 0; empty SHALL read all-ones and meta_rdata 32'h0.
REQ-025 Pushes and acks presented in a reset cycle SHALL be ignored; assertion mid-operation SHALL discard all queued entries.
REQ-026 Storage arrays need no reset.

Structure
REQ-027 NUM_PORTS, DEPTH, META_W and the 32-bit bus word width SHALL be defined in the shared switch package.
REQ-028 A single-port queue SHALL be a sub-module named meta_fifo, instantiated NUM_PORTS times; it holds storage, pointers, count, the ack edge detector, and the drop counter.
REQ-029 The top level SHALL contain only the instances and the rd_port output mux.

Verification
REQ-030 Push 31'h1234 on port 2, set rd_port=2 -> meta_rdata=32'h80001234 next cycle, count[2]=1, empty[2]=0.
REQ-031 Push A,B,C on port 0, raise ack[0] high for 3 cycles, drop it, raise it again -> exactly two pops; meta_rdata = B, then C; count[0] goes 3->2->1.
REQ-032 Push 6 words on port 1 without acks -> count[1]=4, drop_cnt[1]=2, head = first word; then 300 further pushes -> drop_cnt[1]=8'hFF.
REQ-033 With port 3 full, push plus ack rising edge in the same cycle -> count[3] stays 4, drop_cnt[3]=0, head advances, and the new word is last out.
REQ-034 Ack rising edge on empty port 0 -> no change; rd_port=0 gives meta_rdata=32'h0.
REQ-035 Fill ports 0-3 with 2 entries each, assert reset 1 cycle -> all counts 0, empty=4'hF, drop_cnt 0; a push on the reset cycle is not stored.

Source files
------------

// File: rtl/egress_meta_queue_pkg.sv
// Shared switch constants for the egress metadata queues.
// Holds the per-port queue geometry and the software bus word width.
package egress_meta_queue_pkg;

    localparam int EMQ_NUM_PORTS  = 4;
    localparam int EMQ_DEPTH      = 4;
    localparam int EMQ_META_W     = 31;
    localparam int EMQ_BUS_W      = 32;
    localparam int EMQ_DROP_W     = 8;
    localparam int EMQ_PORT_SEL_W = 2;

endpackage

// File: rtl/egress_meta_queue_meta_fifo.sv
// Single-port metadata FIFO: storage, pointers, occupancy, ack edge
// detector and a saturating drop counter for pushes that find it full.
module meta_fifo
    import egress_meta_queue_pkg::*;
#(
    parameter int DEPTH  = EMQ_DEPTH,
    parameter int META_W = EMQ_META_W,
    parameter int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [META_W-1:0]     meta_i,
    input  logic                  ack_i,
    output logic [META_W-1:0]     head_o,
    output logic                  empty_o,
    output logic [CNT_W-1:0]      count_o,
    output logic [EMQ_DROP_W-1:0] drop_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [META_W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [EMQ_DROP_W-1:0] drop_q, drop_d;
    logic                  ackPrev_q;

    logic ackRise;
    logic isEmpty;
    logic isFull;
    logic doPop;
    logic doPush;
    logic doDrop;

    // Decide this cycle's events; a pop frees a slot so a full queue can still accept a push.
    always_comb begin
        ackRise = ack_i & ~ackPrev_q;
        isEmpty = (count_q == '0);
        isFull  = (count_q == FULL_CNT);
        doPop   = ackRise & ~isEmpty;
        doPush  = push_i & (~isFull | doPop);
        doDrop  = push_i & isFull & ~doPop;
    end

    // Next-state for pointers, occupancy and the saturating drop counter.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        drop_d  = drop_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (doDrop && (drop_q != '1)) begin
            drop_d = drop_q + EMQ_DROP_W'(1);
        end
    end

    // Control state register with synchronous reset that also discards queued entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            drop_q    <= '0;
            ackPrev_q <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
            ackPrev_q <= ack_i;
        end
    end

    // Entry storage; contents are don't-care until written so no reset is needed.
    always_ff @(posedge clk) begin
        if (doPush && !reset) begin
            mem_q[wrPtr_q] <= meta_i;
        end
    end

    assign head_o  = mem_q[rdPtr_q];
    assign empty_o = isEmpty;
    assign count_o = count_q;
    assign drop_o  = drop_q;

endmodule

// File: rtl/egress_meta_queue.sv
// Egress metadata queue block: one meta_fifo per egress port plus the
// software-bus read mux that presents the selected queue head.
module egress_meta_queue
    import egress_meta_queue_pkg::*;
#(
    parameter int NUM_PORTS = EMQ_NUM_PORTS,
    parameter int DEPTH     = EMQ_DEPTH,
    parameter int META_W    = EMQ_META_W,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            eg_valid,
    input  logic [NUM_PORTS*META_W-1:0]     eg_meta,
    input  logic [EMQ_PORT_SEL_W-1:0]       rd_port,
    input  logic [NUM_PORTS-1:0]            ack,
    output logic [EMQ_BUS_W-1:0]            meta_rdata,
    output logic [NUM_PORTS-1:0]            empty,
    output logic [NUM_PORTS*CNT_W-1:0]      count,
    output logic [NUM_PORTS*EMQ_DROP_W-1:0] drop_cnt
);

    logic [META_W-1:0] head [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        meta_fifo #(
            .DEPTH  (DEPTH),
            .META_W (META_W),
            .CNT_W  (CNT_W)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (eg_valid[p]),
            .meta_i  (eg_meta[p*META_W +: META_W]),
            .ack_i   (ack[p]),
            .head_o  (head[p]),
            .empty_o (empty[p]),
            .count_o (count[p*CNT_W +: CNT_W]),
            .drop_o  (drop_cnt[p*EMQ_DROP_W +: EMQ_DROP_W])
        );
    end

    // Bus read word: valid flag in the MSB with the head entry, or zero when the queue is empty.
    always_comb begin
        meta_rdata = '0;
        if (!empty[rd_port]) begin
            meta_rdata[EMQ_BUS_W-1]  = 1'b1;
            meta_rdata[META_W-1:0]   = head[rd_port];
        end
    end

endmodule

// File: tb/tb_egress_meta_queue.sv
// Self-checking bench for egress_meta_queue: a scoreboard model of every
// port queue checked each cycle, a vector table, and directed corner cases.
module tb_egress_meta_queue;
    import egress_meta_queue_pkg::*;

    localparam int NP = 4;
    localparam int MW = 31;
    localparam int CW = 3;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NP-1:0]    eg_valid;
    logic [NP*MW-1:0] eg_meta;
    logic [1:0]       rd_port;
    logic [NP-1:0]    ack;
    logic [31:0]      meta_rdata;
    logic [NP-1:0]    empty;
    logic [NP*CW-1:0] count;
    logic [NP*DW-1:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    logic [MW-1:0] mq [NP][$];
    int            mdrop [NP];
    logic          mAckPrev [NP];

    typedef struct {
        logic [NP-1:0] valid;
        logic [MW-1:0] meta;
        logic [NP-1:0] ackV;
        logic [1:0]    rdPort;
        logic [31:0]   expRdata;
        logic [2:0]    expCount;
        logic [NP-1:0] expEmpty;
    } vec_t;

    vec_t vecs [11];

    egress_meta_queue #(
        .NUM_PORTS (NP),
        .DEPTH     (4),
        .META_W    (MW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .eg_valid   (eg_valid),
        .eg_meta    (eg_meta),
        .rd_port    (rd_port),
        .ack        (ack),
        .meta_rdata (meta_rdata),
        .empty      (empty),
        .count      (count),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] cntOf(input int p);
        return count[p*CW +: CW];
    endfunction

    function automatic logic [DW-1:0] dropOf(input int p);
        return drop_cnt[p*DW +: DW];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard model update for the inputs present at this clock edge.
    task automatic modelUpdate();
        for (int p = 0; p < NP; p++) begin
            if (reset) begin
                mq[p].delete();
                mdrop[p]    = 0;
                mAckPrev[p] = 1'b0;
            end else begin
                if (ack[p] && !mAckPrev[p] && mq[p].size() > 0) begin
                    void'(mq[p].pop_front());
                end
                if (eg_valid[p]) begin
                    if (mq[p].size() < 4) begin
                        mq[p].push_back(eg_meta[p*MW +: MW]);
                    end else if (mdrop[p] < 255) begin
                        mdrop[p]++;
                    end
                end
                mAckPrev[p] = ack[p];
            end
        end
    endtask

    task automatic compareAll();
        logic [31:0] expR;
        for (int p = 0; p < NP; p++) begin
            checkOutput($sformatf("count%0d", p), 32'(cntOf(p)), 32'(mq[p].size()));
            checkOutput($sformatf("empty%0d", p), 32'(empty[p]), 32'(mq[p].size() == 0));
            checkOutput($sformatf("drop%0d", p), 32'(dropOf(p)), 32'(mdrop[p]));
        end
        expR = 32'h0;
        if (mq[rd_port].size() > 0) expR = {1'b1, mq[rd_port][0]};
        checkOutput("rdata", meta_rdata, expR);
    endtask

    task automatic cycleStep();
        @(posedge clk);
        modelUpdate();
        #1;
        compareAll();
    endtask

    task automatic applyStimulus(input logic [NP-1:0] v, input logic [MW-1:0] m,
                                 input logic [NP-1:0] a, input logic [1:0] rp);
        eg_valid = v;
        for (int p = 0; p < NP; p++) eg_meta[p*MW +: MW] = m;
        ack     = a;
        rd_port = rp;
        cycleStep();
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus('0, '0, '0, 2'd0);
        applyStimulus('0, '0, '0, 2'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        eg_valid = '0;
        eg_meta  = '0;
        ack      = '0;
        rd_port  = 2'd0;

        vecs[0]  = '{4'b0100, 31'h1234, 4'b0000, 2'd2, 32'h80001234, 3'd1, 4'b1011};
        vecs[1]  = '{4'b0000, 31'h0,    4'b0000, 2'd0, 32'h00000000, 3'd0, 4'b1011};
        vecs[2]  = '{4'b0000, 31'h0,    4'b0001, 2'd0, 32'h00000000, 3'd0, 4'b1011};
        vecs[3]  = '{4'b0001, 31'h55,   4'b0000, 2'd0, 32'h80000055, 3'd1, 4'b1010};
        vecs[4]  = '{4'b0001, 31'h66,   4'b0000, 2'd0, 32'h80000055, 3'd2, 4'b1010};
        vecs[5]  = '{4'b0000, 31'h0,    4'b0100, 2'd2, 32'h00000000, 3'd0, 4'b1110};
        vecs[6]  = '{4'b0000, 31'h0,    4'b0101, 2'd0, 32'h80000066, 3'd1, 4'b1110};
        vecs[7]  = '{4'b0001, 31'h77,   4'b0101, 2'd0, 32'h80000066, 3'd2, 4'b1110};
        vecs[8]  = '{4'b0000, 31'h0,    4'b0000, 2'd0, 32'h80000066, 3'd2, 4'b1110};
        vecs[9]  = '{4'b0001, 31'h88,   4'b0001, 2'd0, 32'h80000077, 3'd2, 4'b1110};
        vecs[10] = '{4'b1000, 31'h3,    4'b0000, 2'd3, 32'h80000003, 3'd1, 4'b0110};

        doReset();
        checkOutput("reset_empty", 32'(empty), 32'hF);
        checkOutput("reset_rdata", meta_rdata, 32'h0);

        // Table-driven vectors from reset.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].meta, vecs[i].ackV, vecs[i].rdPort);
            checkOutput($sformatf("vec%0d_rdata", i), meta_rdata, vecs[i].expRdata);
            checkOutput($sformatf("vec%0d_count", i), 32'(cntOf(int'(vecs[i].rdPort))), 32'(vecs[i].expCount));
            checkOutput($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].expEmpty));
        end
        applyStimulus('0, '0, '0, 2'd0);

        // Held ack pops once; a second rising edge pops again.
        doReset();
        applyStimulus(4'b0001, 31'h0A, '0, 2'd0);
        applyStimulus(4'b0001, 31'h0B, '0, 2'd0);
        applyStimulus(4'b0001, 31'h0C, '0, 2'd0);
        applyStimulus('0, '0, '0, 2'd0);
        checkOutput("ack_cnt3", 32'(cntOf(0)), 32'd3);
        applyStimulus('0, '0, 4'b0001, 2'd0);
        checkOutput("ack_cnt2", 32'(cntOf(0)), 32'd2);
        checkOutput("ack_headB", meta_rdata, 32'h8000000B);
        applyStimulus('0, '0, 4'b0001, 2'd0);
        applyStimulus('0, '0, 4'b0001, 2'd0);
        checkOutput("ack_hold", 32'(cntOf(0)), 32'd2);
        applyStimulus('0, '0, '0, 2'd0);
        applyStimulus('0, '0, 4'b0001, 2'd0);
        checkOutput("ack_cnt1", 32'(cntOf(0)), 32'd1);
        checkOutput("ack_headC", meta_rdata, 32'h8000000C);
        applyStimulus('0, '0, '0, 2'd0);

        // Overflow drops and drop counter saturation.
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(4'b0010, 31'(32'h100 + i), '0, 2'd1);
        applyStimulus('0, '0, '0, 2'd1);
        checkOutput("ovf_cnt", 32'(cntOf(1)), 32'd4);
        checkOutput("ovf_drop", 32'(dropOf(1)), 32'd2);
        checkOutput("ovf_head", meta_rdata, 32'h80000100);
        for (int i = 0; i < 300; i++) applyStimulus(4'b0010, 31'(32'h500 + i), '0, 2'd1);
        applyStimulus('0, '0, '0, 2'd1);
        checkOutput("sat_drop", 32'(dropOf(1)), 32'hFF);
        checkOutput("sat_head", meta_rdata, 32'h80000100);

        // Push and pop together on a full queue.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(4'b1000, 31'(32'h200 + i), '0, 2'd3);
        applyStimulus(4'b1000, 31'h204, 4'b1000, 2'd3);
        checkOutput("full_pp_cnt", 32'(cntOf(3)), 32'd4);
        checkOutput("full_pp_drop", 32'(dropOf(3)), 32'd0);
        checkOutput("full_pp_head", meta_rdata, 32'h80000201);
        for (int i = 0; i < 3; i++) begin
            applyStimulus('0, '0, '0, 2'd3);
            applyStimulus('0, '0, 4'b1000, 2'd3);
            checkOutput($sformatf("drain%0d", i), meta_rdata, 32'h80000202 + 32'(i));
        end
        applyStimulus('0, '0, '0, 2'd3);
        applyStimulus('0, '0, 4'b1000, 2'd3);
        checkOutput("drain_empty", meta_rdata, 32'h0);
        applyStimulus('0, '0, '0, 2'd3);

        // Mid-operation reset discards everything, including a same-cycle push.
        doReset();
        applyStimulus(4'b1111, 31'h300, '0, 2'd2);
        applyStimulus(4'b1111, 31'h301, '0, 2'd2);
        checkOutput("fill_cnt2", 32'(cntOf(2)), 32'd2);
        reset = 1'b1;
        applyStimulus(4'b1111, 31'h3FF, 4'b1111, 2'd2);
        reset = 1'b0;
        checkOutput("rst_empty", 32'(empty), 32'hF);
        checkOutput("rst_count", 32'(count), 32'h0);
        checkOutput("rst_drop", drop_cnt, 32'h0);
        applyStimulus('0, '0, '0, 2'd2);
        checkOutput("rst_nopush", 32'(empty), 32'hF);
        checkOutput("rst_rdata", meta_rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
